// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm_pkg
// Purpose  : Definitions shared by the credit accumulator and its adder:
//            default widths and the controller state enumeration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vm_pkg;

    // Width of a coin value and of the credit register.
    localparam int WIDTH_DEF = 5;
    // Width of the saturating accepted-coin counter.
    localparam int CNT_W_DEF = 4;

    // IDLE  : credit and coin count both zero, coins accepted
    // ACCUM : something has been paid in, coins still accepted
    // HOLD  : credit offered downstream, coins refused
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/adder5.sv
`default_nettype none
// ============================================================================
// Module   : adder5
// Purpose  : Unsigned WIDTH-bit adder with separate carry out. Used to form
//            credit + coin; the carry tells the controller the coin would
//            overflow the credit register.
// Ports    : a     - first addend  (WIDTH)
//            b     - second addend (WIDTH)
//            sum   - low WIDTH bits of a + b
//            carry - bit WIDTH of a + b
// Revision : 1.0 - initial release
// ============================================================================
module adder5
    import vm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Extend both operands by one bit so the full WIDTH+1 result is kept.
    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign sum    = w_full[WIDTH-1:0];
    assign carry  = w_full[WIDTH];

endmodule : adder5
`default_nettype wire

// File: rtl/credit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : credit_accumulator
// Purpose  : Accumulates coin values into a credit register, counts accepted
//            coins, refuses coins that would overflow, and either hands the
//            credit downstream (commit / out_ready) or refunds it (cancel).
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            coin_valid, coin_val  - offered coin
//            coin_ready            - coin can be taken this cycle
//            commit, cancel        - single-cycle control requests
//            credit, coin_cnt      - current credit / accepted-coin count
//            coin_reject           - pulse: last offered coin overflowed
//            out_valid, out_credit - credit offered downstream
//            out_ready             - downstream takes out_credit
//            refund_valid, refund_amt - pulse with the refunded credit
// Revision : 1.0 - initial release
// ============================================================================
module credit_accumulator
    import vm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [WIDTH-1:0] coin_val,
    output logic             coin_ready,
    input  logic             commit,
    input  logic             cancel,
    output logic [WIDTH-1:0] credit,
    output logic [CNT_W-1:0] coin_cnt,
    output logic             coin_reject,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_credit,
    input  logic             out_ready,
    output logic             refund_valid,
    output logic [WIDTH-1:0] refund_amt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_credit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_reject;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_credit;
    logic             r_refund_valid;
    logic [WIDTH-1:0] r_refund_amt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_nx;
    logic [WIDTH-1:0] w_credit_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_reject_nx;
    logic             w_out_valid_nx;
    logic [WIDTH-1:0] w_out_credit_nx;
    logic             w_refund_valid_nx;
    logic [WIDTH-1:0] w_refund_amt_nx;

    logic             w_coin_hs;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [CNT_W-1:0] w_cnt_inc;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    adder5 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (r_credit),
        .b     (coin_val),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // coin_ready is a pure decode of the state register, so it carries no
    // combinational path from any input.
    assign coin_ready = (r_state != ST_HOLD);
    assign w_coin_hs  = coin_valid && coin_ready;
    assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx        = r_state;
        w_credit_nx       = r_credit;
        w_cnt_nx          = r_cnt;
        w_reject_nx       = 1'b0;
        w_refund_valid_nx = 1'b0;
        w_refund_amt_nx   = '0;

        case (r_state)
            ST_HOLD: begin
                // A completed handoff wins over a same-edge cancel.
                if (out_ready) begin
                    w_credit_nx = '0;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_IDLE;
                end else if (cancel) begin
                    w_refund_valid_nx = 1'b1;
                    w_refund_amt_nx   = r_credit;
                    w_credit_nx       = '0;
                    w_cnt_nx          = '0;
                    w_state_nx        = ST_IDLE;
                end
            end

            ST_IDLE, ST_ACCUM: begin
                // Cancel only means something once there is credit or a
                // count to give back; it then discards any same-edge coin.
                if (cancel && (r_state == ST_ACCUM)) begin
                    w_refund_valid_nx = 1'b1;
                    w_refund_amt_nx   = r_credit;
                    w_credit_nx       = '0;
                    w_cnt_nx          = '0;
                    w_state_nx        = ST_IDLE;
                end else begin
                    // Coin first, so a same-edge commit holds the result.
                    if (w_coin_hs) begin
                        if (w_carry) begin
                            w_reject_nx = 1'b1;
                        end else begin
                            w_credit_nx = w_sum;
                            w_cnt_nx    = w_cnt_inc;
                            w_state_nx  = ST_ACCUM;
                        end
                    end
                    if (commit && (r_state == ST_ACCUM)) begin
                        w_state_nx = ST_HOLD;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                w_credit_nx = '0;
                w_cnt_nx    = '0;
                w_state_nx  = ST_IDLE;
            end
        endcase

        w_out_valid_nx  = (w_state_nx == ST_HOLD);
        w_out_credit_nx = w_out_valid_nx ? w_credit_nx : '0;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_cnt          <= '0;
            r_reject       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_credit   <= '0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_credit       <= w_credit_nx;
            r_cnt          <= w_cnt_nx;
            r_reject       <= w_reject_nx;
            r_out_valid    <= w_out_valid_nx;
            r_out_credit   <= w_out_credit_nx;
            r_refund_valid <= w_refund_valid_nx;
            r_refund_amt   <= w_refund_amt_nx;
        end
    end

    assign credit       = r_credit;
    assign coin_cnt     = r_cnt;
    assign coin_reject  = r_reject;
    assign out_valid    = r_out_valid;
    assign out_credit   = r_out_credit;
    assign refund_valid = r_refund_valid;
    assign refund_amt   = r_refund_amt;

endmodule : credit_accumulator
`default_nettype wire

// File: tb/tb_credit_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_accumulator
// Purpose  : Self-checking bench for credit_accumulator. A value-level model
//            (credit, count, "offered downstream" flag) predicts every output;
//            directed scenarios pin known values, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_credit_accumulator;

    localparam int W   = 5;
    localparam int CW  = 4;
    localparam int MAXC = (1 << W) - 1;
    localparam int MAXN = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coin_valid = 1'b0;
    logic [W-1:0]  coin_val = '0;
    logic          coin_ready;
    logic          commit = 1'b0;
    logic          cancel = 1'b0;
    logic [W-1:0]  credit;
    logic [CW-1:0] coin_cnt;
    logic          coin_reject;
    logic          out_valid;
    logic [W-1:0]  out_credit;
    logic          out_ready = 1'b0;
    logic          refund_valid;
    logic [W-1:0]  refund_amt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    credit_accumulator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .coin_ready   (coin_ready),
        .commit       (commit),
        .cancel       (cancel),
        .credit       (credit),
        .coin_cnt     (coin_cnt),
        .coin_reject  (coin_reject),
        .out_valid    (out_valid),
        .out_credit   (out_credit),
        .out_ready    (out_ready),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the state is implied by the values themselves.
    // ------------------------------------------------------------------
    typedef struct packed {
        int credit;
        int cnt;
        bit held;
        bit rej;
        bit rv;
        int ramt;
    } model_t;

    model_t m;

    function automatic model_t step_model(model_t c, bit cv, int val, bit cm,
                                          bit cn, bit ordy);
        model_t n;
        bit     paid;
        n      = c;
        n.rej  = 1'b0;
        n.rv   = 1'b0;
        n.ramt = 0;
        paid   = (c.credit != 0) || (c.cnt != 0);
        if (c.held) begin
            if (ordy) begin
                n.credit = 0; n.cnt = 0; n.held = 1'b0;
            end else if (cn) begin
                n.rv = 1'b1; n.ramt = c.credit;
                n.credit = 0; n.cnt = 0; n.held = 1'b0;
            end
        end else if (cn && paid) begin
            n.rv = 1'b1; n.ramt = c.credit;
            n.credit = 0; n.cnt = 0;
        end else begin
            if (cv) begin
                if (c.credit + val > MAXC) begin
                    n.rej = 1'b1;
                end else begin
                    n.credit = c.credit + val;
                    n.cnt    = (c.cnt + 1 > MAXN) ? MAXN : c.cnt + 1;
                end
            end
            if (cm && paid) n.held = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step_model(m, coin_valid, int'(coin_val), commit,
                                    cancel, out_ready);
    end

    // Single compare process: every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("credit",       int'(credit),       m.credit);
            chk("coin_cnt",     int'(coin_cnt),     m.cnt);
            chk("coin_ready",   int'(coin_ready),   int'(!m.held));
            chk("out_valid",    int'(out_valid),    int'(m.held));
            chk("out_credit",   int'(out_credit),   m.held ? m.credit : 0);
            chk("coin_reject",  int'(coin_reject),  int'(m.rej));
            chk("refund_valid", int'(refund_valid), int'(m.rv));
            chk("refund_amt",   int'(refund_amt),   m.rv ? m.ramt : 0);
        end
    end

    // Apply one cycle of inputs; returns 1 ns after the capturing edge.
    task automatic cyc(input bit cv, input int val, input bit cm, input bit cn,
                       input bit ordy);
        coin_valid = cv;
        coin_val   = W'(val);
        commit     = cm;
        cancel     = cn;
        out_ready  = ordy;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        commit     = 1'b0;
        cancel     = 1'b0;
        out_ready  = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_credit",  int'(credit),     0);
        chk("rst_ready",   int'(coin_ready), 1);
        chk("rst_ovalid",  int'(out_valid),  0);

        // Two coins, commit, handoff.
        cyc(1, 10, 0, 0, 0); chk("s1_credit10", int'(credit), 10);
        cyc(1, 5, 0, 0, 0);  chk("s1_credit15", int'(credit), 15);
        cyc(0, 0, 1, 0, 0);
        chk("s1_ovalid", int'(out_valid), 1);
        chk("s1_ocredit", int'(out_credit), 15);
        cyc(0, 0, 0, 0, 1);
        chk("s1_clr_credit", int'(credit), 0);
        chk("s1_clr_cnt", int'(coin_cnt), 0);
        chk("s1_clr_ready", int'(coin_ready), 1);

        // Overflow rejection.
        cyc(1, 10, 0, 0, 0); cyc(1, 10, 0, 0, 0); cyc(1, 5, 0, 0, 0);
        chk("s2_credit25", int'(credit), 25);
        cyc(1, 10, 0, 0, 0);
        chk("s2_reject", int'(coin_reject), 1);
        chk("s2_hold25", int'(credit), 25);
        chk("s2_cnt3", int'(coin_cnt), 3);
        cyc(0, 0, 0, 0, 0); chk("s2_reject_pulse", int'(coin_reject), 0);
        cyc(1, 6, 0, 0, 0);
        chk("s2_credit31", int'(credit), 31);
        chk("s2_noreject", int'(coin_reject), 0);
        cyc(0, 0, 0, 1, 0);
        chk("s2_refund31", int'(refund_amt), 31);

        // Cancel in idle does nothing.
        cyc(0, 0, 0, 1, 0); chk("idle_cancel", int'(refund_valid), 0);

        // Coin and commit on the same edge.
        cyc(1, 20, 0, 0, 0);
        cyc(1, 5, 1, 0, 0);
        chk("s3_ocredit25", int'(out_credit), 25);
        chk("s3_notready", int'(coin_ready), 0);
        cyc(1, 3, 0, 0, 0); chk("s3_still25", int'(credit), 25);
        cyc(0, 0, 0, 0, 1);

        // Cancel in HOLD, then cancel racing out_ready.
        cyc(1, 12, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("s4_rvalid", int'(refund_valid), 1);
        chk("s4_ramt12", int'(refund_amt), 12);
        chk("s4_credit0", int'(credit), 0);
        cyc(0, 0, 0, 0, 0); chk("s4_rvalid_pulse", int'(refund_valid), 0);
        cyc(1, 12, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        chk("s4_offer12", int'(out_credit), 12);
        cyc(0, 0, 0, 1, 1);
        chk("s4_norefund", int'(refund_valid), 0);
        chk("s4_handoff", int'(out_valid), 0);

        // Counter saturation.
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0);
        chk("s5_cnt15", int'(coin_cnt), 15);
        chk("s5_credit16", int'(credit), 16);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset in HOLD.
        cyc(1, 7, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        chk("s6_inhold", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("s6_ovalid0", int'(out_valid), 0);
        chk("s6_ocredit0", int'(out_credit), 0);
        chk("s6_credit0", int'(credit), 0);
        chk("s6_cnt0", int'(coin_cnt), 0);
        chk("s6_rvalid0", int'(refund_valid), 0);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("s6_ready1", int'(coin_ready), 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit cv, cm, cn, ordy;
            int val;
            cv   = ($urandom_range(0, 99) < 55);
            val  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXC)
                                               : $urandom_range(0, 6);
            cm   = ($urandom_range(0, 99) < 15);
            cn   = ($urandom_range(0, 99) < 4);
            ordy = ($urandom_range(0, 99) < 25);
            cyc(cv, val, cm, cn, ordy);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_credit_accumulator
`default_nettype wire
